nest_checker: RTL



---
 rtl/nest_pkg.sv | 59 +++++
 rtl/nest_type_stack.sv | 55 +++++
 rtl/nest_checker.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/nest_pkg.sv
// Shared definitions for the keyword-nesting checker: error codes, token
// types, lower-case keyword letters and matcher state encodings.
package nest_pkg;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_UNDERFLOW = 2'd1,
        ERR_MISMATCH  = 2'd2,
        ERR_OVERFLOW  = 2'd3
    } err_e;

    localparam logic TOK_BEGIN = 1'b0;
    localparam logic TOK_FORK  = 1'b1;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_B     = 8'h62;
    localparam logic [7:0] CH_D     = 8'h64;
    localparam logic [7:0] CH_E     = 8'h65;
    localparam logic [7:0] CH_F     = 8'h66;
    localparam logic [7:0] CH_G     = 8'h67;
    localparam logic [7:0] CH_I     = 8'h69;
    localparam logic [7:0] CH_J     = 8'h6A;
    localparam logic [7:0] CH_K     = 8'h6B;
    localparam logic [7:0] CH_N     = 8'h6E;
    localparam logic [7:0] CH_O     = 8'h6F;
    localparam logic [7:0] CH_R     = 8'h72;

    typedef enum logic [3:0] {
        ST_START   = 4'd0,
        ST_SKIP    = 4'd1,
        ST_B1      = 4'd2,
        ST_B2      = 4'd3,
        ST_B3      = 4'd4,
        ST_B4      = 4'd5,
        ST_E1      = 4'd6,
        ST_E2      = 4'd7,
        ST_F1      = 4'd8,
        ST_F2      = 4'd9,
        ST_F3      = 4'd10,
        ST_J1      = 4'd11,
        ST_J2      = 4'd12,
        ST_J3      = 4'd13,
        ST_KW_DONE = 4'd14
    } match_state_e;

    // Kind of tentative action held while the matcher sits in ST_KW_DONE.
    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_PUSH = 2'd1,
        PEND_POP  = 2'd2,
        PEND_ERR  = 2'd3
    } pend_e;

    // Fold 'A'-'Z' onto 'a'-'z'; everything else passes unchanged.
    function automatic logic [7:0] to_lower(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) ? (c | 8'h20) : c;
    endfunction

endpackage

// File: rtl/nest_type_stack.sv
// One-bit-wide LIFO holding the type of each open block. Besides push/pop it
// can undo the last push (unpush) or the last pop (unpop); unpop relies on
// pop never clearing the entry it leaves.
module nest_type_stack
    import nest_pkg::*;
#(
    parameter int MAX_DEPTH = 16,
    parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               unpush,
    input  logic               unpop,
    input  logic               push_type,
    output logic [DEPTH_W-1:0] sp,
    output logic               top,
    output logic               empty,
    output logic               full
);

    localparam int IDX_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    logic             mem [MAX_DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    // Push only happens when not full, so sp fits the entry index here.
    assign wr_idx  = IDX_W'(sp);
    assign top_idx = IDX_W'(sp - DEPTH_W'(1));

    assign empty = (sp == '0);
    assign full  = (sp == DEPTH_W'(MAX_DEPTH));
    assign top   = empty ? TOK_BEGIN : mem[top_idx];

    // Entry storage; no reset needed since reads are gated by sp.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_type;
        end
    end

    // Stack pointer; the controller never asserts two operations at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (push || unpop) begin
            sp <= sp + DEPTH_W'(1);
        end else if (pop || unpush) begin
            sp <= sp - DEPTH_W'(1);
        end
    end

endmodule

// File: rtl/nest_checker.sv
// Streaming case-insensitive begin/end + fork/join nesting checker.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_START   | after a space or reset, next char starts a word
// ST_SKIP    | inside a word that cannot be a keyword
// ST_B1..B4  | seen "b", "be", "beg", "begi"
// ST_E1..E2  | seen "e", "en"
// ST_F1..F3  | seen "f", "fo", "for"
// ST_J1..J3  | seen "j", "jo", "joi"
// ST_KW_DONE | full keyword seen; its stack action is tentative until the
//            | next accepted char (space commits, anything else undoes)
module nest_checker
    import nest_pkg::*;
#(
    parameter int MAX_DEPTH = 16,
    parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1),
    parameter bit EN_FORK   = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in,
    input  logic               in_valid,
    output logic               result,
    output logic [DEPTH_W-1:0] depth,
    output logic [1:0]         err
);

    match_state_e state_q, state_d;
    pend_e        pend_q, pend_d;
    err_e         pend_err_q, pend_err_d;
    err_e         err_q, err_d;

    logic [7:0]         ch;
    logic               kw_done;
    logic               kw_close;
    logic               kw_type;
    logic               stk_push, stk_pop, stk_unpush, stk_unpop;
    logic               stk_push_type;
    logic [DEPTH_W-1:0] stk_sp;
    logic               stk_top, stk_empty, stk_full;

    assign ch = to_lower(in);

    nest_type_stack #(
        .MAX_DEPTH (MAX_DEPTH),
        .DEPTH_W   (DEPTH_W)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .unpush    (stk_unpush),
        .unpop     (stk_unpop),
        .push_type (stk_push_type),
        .sp        (stk_sp),
        .top       (stk_top),
        .empty     (stk_empty),
        .full      (stk_full)
    );

    // Matcher state, pending action and sticky committed error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_START;
            pend_q     <= PEND_NONE;
            pend_err_q <= ERR_NONE;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_err_q <= pend_err_d;
            err_q      <= err_d;
        end
    end

    // Next-state decode, commit/undo of the tentative action, stack control.
    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        pend_err_d    = pend_err_q;
        err_d         = err_q;
        kw_done       = 1'b0;
        kw_close      = 1'b0;
        kw_type       = TOK_BEGIN;
        stk_push      = 1'b0;
        stk_pop       = 1'b0;
        stk_unpush    = 1'b0;
        stk_unpop     = 1'b0;
        stk_push_type = TOK_BEGIN;

        if (in_valid) begin
            if (ch == CH_SPACE) begin
                state_d = ST_START;
                if (state_q == ST_KW_DONE) begin
                    // Stack changes are already in place; only errors need latching.
                    if (pend_q == PEND_ERR) begin
                        err_d = pend_err_q;
                    end
                    pend_d     = PEND_NONE;
                    pend_err_d = ERR_NONE;
                end
            end else begin
                case (state_q)
                    ST_START: begin
                        if (ch == CH_B) begin
                            state_d = ST_B1;
                        end else if (ch == CH_E) begin
                            state_d = ST_E1;
                        end else if (EN_FORK && (ch == CH_F)) begin
                            state_d = ST_F1;
                        end else if (EN_FORK && (ch == CH_J)) begin
                            state_d = ST_J1;
                        end else begin
                            state_d = ST_SKIP;
                        end
                    end
                    ST_B1: state_d = (ch == CH_E) ? ST_B2 : ST_SKIP;
                    ST_B2: state_d = (ch == CH_G) ? ST_B3 : ST_SKIP;
                    ST_B3: state_d = (ch == CH_I) ? ST_B4 : ST_SKIP;
                    ST_B4: begin
                        state_d = ST_SKIP;
                        if (ch == CH_N) begin
                            state_d  = ST_KW_DONE;
                            kw_done  = 1'b1;
                            kw_close = 1'b0;
                            kw_type  = TOK_BEGIN;
                        end
                    end
                    ST_E1: state_d = (ch == CH_N) ? ST_E2 : ST_SKIP;
                    ST_E2: begin
                        state_d = ST_SKIP;
                        if (ch == CH_D) begin
                            state_d  = ST_KW_DONE;
                            kw_done  = 1'b1;
                            kw_close = 1'b1;
                            kw_type  = TOK_BEGIN;
                        end
                    end
                    ST_F1: state_d = (ch == CH_O) ? ST_F2 : ST_SKIP;
                    ST_F2: state_d = (ch == CH_R) ? ST_F3 : ST_SKIP;
                    ST_F3: begin
                        state_d = ST_SKIP;
                        if (ch == CH_K) begin
                            state_d  = ST_KW_DONE;
                            kw_done  = 1'b1;
                            kw_close = 1'b0;
                            kw_type  = TOK_FORK;
                        end
                    end
                    ST_J1: state_d = (ch == CH_O) ? ST_J2 : ST_SKIP;
                    ST_J2: state_d = (ch == CH_I) ? ST_J3 : ST_SKIP;
                    ST_J3: begin
                        state_d = ST_SKIP;
                        if (ch == CH_N) begin
                            state_d  = ST_KW_DONE;
                            kw_done  = 1'b1;
                            kw_close = 1'b1;
                            kw_type  = TOK_FORK;
                        end
                    end
                    ST_KW_DONE: begin
                        // Keyword turned out to be a prefix of a longer word.
                        state_d    = ST_SKIP;
                        stk_unpush = (pend_q == PEND_PUSH);
                        stk_unpop  = (pend_q == PEND_POP);
                        pend_d     = PEND_NONE;
                        pend_err_d = ERR_NONE;
                    end
                    default: state_d = ST_SKIP;
                endcase
            end
        end

        // Once an error is committed the stack is frozen for good.
        if (kw_done && (err_q == ERR_NONE)) begin
            if (!kw_close) begin
                if (stk_full) begin
                    pend_d     = PEND_ERR;
                    pend_err_d = ERR_OVERFLOW;
                end else begin
                    pend_d        = PEND_PUSH;
                    stk_push      = 1'b1;
                    stk_push_type = EN_FORK ? kw_type : TOK_BEGIN;
                end
            end else if (stk_empty) begin
                pend_d     = PEND_ERR;
                pend_err_d = ERR_UNDERFLOW;
            end else if (stk_top != kw_type) begin
                pend_d     = PEND_ERR;
                pend_err_d = ERR_MISMATCH;
            end else begin
                pend_d  = PEND_POP;
                stk_pop = 1'b1;
            end
        end
    end

    assign depth  = stk_sp;
    assign err    = (err_q != ERR_NONE) ? err_q : pend_err_q;
    assign result = (err == 2'd0) && (depth == '0);

endmodule
